uart_tx: RTL and testbench
==========================

Name: uart_tx

Overview:
- UART transmitter that drains bytes from an upstream first-word-fallthrough FIFO.
- Serialises each byte as 8N1: start bit, 8 data bits LSB first, 1 stop bit.
- Sits in the peripheral subsystem between the CPU-written TX FIFO and the pad.
- Bit period is set at run time by a divisor register.

Parameters:
- DATA_BITS, 8, data bits per frame.
- DIV_WIDTH, 16, width of the baud divisor.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- tx_en  input  1  transmit enable; frames start only while high.
- baud_div  input  DIV_WIDTH  bit period minus one, in clk cycles.
- parity_odd  input  1  parity sense; used only when UART_TX_PARITY_EN is defined.
- fifo_empty  input  1  upstream FIFO empty.
- fifo_dout  input  DATA_BITS  upstream FIFO head word; valid while !fifo_empty.
- fifo_rd_en  output  1  pop strobe to the upstream FIFO.
- tx  output  1  serial line; idles high.
- busy  output  1  high while a frame is in progress.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: tx=1, busy=0, fifo_rd_en=0, state=IDLE, counters=0.
- Reset mid-frame: tx returns high immediately and the partial frame is abandoned.
- Upstream FIFO: first-word-fallthrough. fifo_dout is valid whenever !fifo_empty; a one-cycle fifo_rd_en pops it.
- fifo_rd_en is registered and asserts for exactly one cycle per frame. It is never asserted while fifo_empty=1.
- States: IDLE, START, DATA, (PARITY), STOP.
- IDLE -> START: taken when tx_en && !fifo_empty.
  - In that cycle: fifo_dout is latched into the shift register, baud_div is latched, and the fifo_rd_en pulse is registered.
  - Next cycle: tx=0 and busy=1.
- Bit timing: every bit lasts latched_div+1 cycles. baud_div=0 gives 1 cycle per bit.
- Changes to baud_div mid-frame are ignored until the next frame starts.
- DATA: shifts LSB first, bit counter 0..DATA_BITS-1, then moves to PARITY if built in, else STOP.
- STOP: tx=1 for one bit period. On its final cycle:
  - If tx_en && !fifo_empty: pop and go directly to START with zero idle gap; busy stays 1.
  - Otherwise: go to IDLE and busy drops to 0 on the next cycle.
- tx_en deasserted mid-frame: the current frame completes; no new frame starts.
- Back-to-back throughput: one frame per (DATA_BITS+2[+1])*(baud_div+1) cycles.
- tx is driven from a flop (glitch-free).

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined: a PARITY state is inserted after DATA and lasts one bit period.
  - Bit value is XOR of the data bits, inverted when parity_odd=1.
  - parity_odd is sampled at frame start.
- Undefined: no PARITY state. parity_odd is unused and the frame is 8N1.

Decomposition:
- Package uart_pkg holds:
  - tx_state_t enum {IDLE, START, DATA, PARITY, STOP};
  - the DATA_BITS default constant;
  - the frame-length helper function.
- One sub-module, uart_baud_gen:
  - Loadable down-counter: load value=latched_div, restart on frame start.
  - Outputs a one-cycle bit_done tick at the end of each bit period.
  - Reusable by a future uart_rx.

Test Plan:
- Reset mid-frame: rst_n low during DATA -> tx=1, busy=0, fifo_rd_en=0 asynchronously; after release, state is IDLE.
- Single byte: baud_div=3, FIFO holds 0xA5, tx_en=1.
  - fifo_rd_en pulses once.
  - tx sequence, 4 cycles per bit: 0,1,0,1,0,0,1,0,1,1.
  - Frame is 40 cycles; busy=1 throughout and falls after stop.
- Back-to-back: FIFO holds 0x00 then 0xFF, baud_div=0.
  - Two 10-cycle frames with no idle cycle between them.
  - Exactly 2 fifo_rd_en pulses; none once fifo_empty=1.
- Divisor change: baud_div switched from 3 to 7 mid-frame.
  - Current frame keeps 4 cycles per bit.
  - Next frame uses 8 cycles per bit.
- tx_en gating: tx_en dropped during DATA.
  - Frame completes, tx stays 1, no further pop although FIFO is non-empty.
  - Raising tx_en starts the next frame.
- UART_TX_PARITY_EN defined, 0xA5 sent:
  - parity_odd=0 gives parity bit 0; parity_odd=1 gives 1.
  - Frame is 11 bit periods.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and helpers for the UART blocks
//
// Contents:
//   UART_DATA_BITS : default number of data bits per frame
//   tx_state_t     : transmitter frame states
//   frame_bits()   : number of bit periods in one frame
// Optional feature macro used by the blocks importing this package:
//   UART_TX_PARITY_EN
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    // Start bit + data bits + optional parity bit + one stop bit.
    function automatic int frame_bits(input int data_bits, input bit with_parity);
        return data_bits + 2 + (with_parity ? 1 : 0);
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - loadable bit-period down-counter with end-of-bit tick
//
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   load        : restart the bit timer; captures load_val as the period
//   run         : count while high (a frame is in progress)
//   load_val    : bit period minus one, in clk cycles
//   bit_done    : high on the last cycle of every bit period
//
// The period captured on load is kept internally, so later changes to
// load_val do not affect the bit timing until the next load.
module uart_baud_gen #(
    parameter int DIV_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic                 run,
    input  logic [DIV_WIDTH-1:0] load_val,
    output logic                 bit_done
);

    logic [DIV_WIDTH-1:0] cnt;
    logic [DIV_WIDTH-1:0] reload;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            reload <= '0;
        end else if (load) begin
            cnt    <= load_val;
            reload <= load_val;
        end else if (run) begin
            if (cnt == '0) begin
                cnt <= reload;
            end else begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    // A period of zero means every running cycle ends a bit.
    assign bit_done = run && (cnt == '0);

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART transmitter draining a first-word-fallthrough FIFO
//
// Frame: start bit, DATA_BITS data bits LSB first, [parity], one stop bit.
// Optional feature macro: UART_TX_PARITY_EN (adds a parity bit after data;
// parity is XOR of the data bits, inverted when parity_odd is set).
//
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   tx_en       : frames start only while high
//   baud_div    : bit period minus one, captured at frame start
//   parity_odd  : parity sense, captured at frame start (parity builds only)
//   fifo_empty  : upstream FIFO empty
//   fifo_dout   : upstream FIFO head word, valid while !fifo_empty
//   fifo_rd_en  : registered one-cycle pop strobe, one per frame
//   tx          : serial line, idles high, driven from a flop
//   busy        : high while a frame is in progress
module uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_BITS = UART_DATA_BITS,
    parameter int DIV_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 tx_en,
    input  logic [DIV_WIDTH-1:0] baud_div,
    input  logic                 parity_odd,
    input  logic                 fifo_empty,
    input  logic [DATA_BITS-1:0] fifo_dout,
    output logic                 fifo_rd_en,
    output logic                 tx,
    output logic                 busy
);

    localparam int CNT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);

    tx_state_t            state;
    logic [DATA_BITS-1:0] shreg;
    logic [CNT_W-1:0]     bit_cnt;
    logic                 bit_done;
    logic                 frame_start;
    logic                 run;

`ifdef UART_TX_PARITY_EN
    logic                 par_bit;
`else
    logic                 unused_parity_odd;
    assign unused_parity_odd = parity_odd;
`endif

    assign run = (state != IDLE);

    // A new frame begins either from IDLE or on the final cycle of a stop
    // bit, which gives back-to-back frames with no idle gap.
    assign frame_start = tx_en && !fifo_empty &&
                         ((state == IDLE) || ((state == STOP) && bit_done));

    uart_baud_gen #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_baud_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (frame_start),
        .run      (run),
        .load_val (baud_div),
        .bit_done (bit_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            shreg      <= '0;
            bit_cnt    <= '0;
            tx         <= 1'b1;
            busy       <= 1'b0;
            fifo_rd_en <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_bit    <= 1'b0;
`endif
        end else begin
            // The head word is captured now; the pop lands next cycle,
            // which is safe because a frame lasts far longer than one cycle.
            fifo_rd_en <= frame_start;

            if (frame_start) begin
                shreg   <= fifo_dout;
                bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
                par_bit <= (^fifo_dout) ^ parity_odd;
`endif
                tx      <= 1'b0;
                busy    <= 1'b1;
                state   <= START;
            end else begin
                case (state)
                    IDLE: begin
                        tx   <= 1'b1;
                        busy <= 1'b0;
                    end

                    START: begin
                        if (bit_done) begin
                            tx    <= shreg[0];
                            shreg <= shreg >> 1;
                            state <= DATA;
                        end
                    end

                    DATA: begin
                        if (bit_done) begin
                            if (bit_cnt == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                                tx    <= par_bit;
                                state <= PARITY;
`else
                                tx    <= 1'b1;
                                state <= STOP;
`endif
                            end else begin
                                tx      <= shreg[0];
                                shreg   <= shreg >> 1;
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end
                    end

`ifdef UART_TX_PARITY_EN
                    PARITY: begin
                        if (bit_done) begin
                            tx    <= 1'b1;
                            state <= STOP;
                        end
                    end
`endif

                    STOP: begin
                        if (bit_done) begin
                            tx    <= 1'b1;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end

                    default: begin
                        tx    <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - self-checking bench for uart_tx against a frame-level model
module tb_uart_tx;

`ifdef UART_TX_PARITY_EN
    localparam int  NB  = 11;
    localparam bit  PAR = 1'b1;
`else
    localparam int  NB  = 10;
    localparam bit  PAR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tx_en = 1'b0;
    logic [15:0] baud_div = 16'd0;
    logic        parity_odd = 1'b0;
    logic        fifo_empty;
    logic [7:0]  fifo_dout;
    logic        fifo_rd_en;
    logic        tx;
    logic        busy;

    uart_tx dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tx_en      (tx_en),
        .baud_div   (baud_div),
        .parity_odd (parity_odd),
        .fifo_empty (fifo_empty),
        .fifo_dout  (fifo_dout),
        .fifo_rd_en (fifo_rd_en),
        .tx         (tx),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    logic [7:0] q[$];

    int checks = 0;
    int failures = 0;

    // Frame-level model: a frame is a list of bit values, each held for
    // m_len cycles; m_t is the cycle index inside the current frame.
    bit          m_in;
    int          m_t;
    int          m_len;
    logic [10:0] m_bits;
    logic        e_tx, e_busy, e_rd;

    int          n_busy, n_rd, n_rise;
    logic        prev_busy;
    logic        obs[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d time=%0t", nm, act, expv, $time);
        end
    endtask

    task automatic fifo_sync();
        fifo_empty = (q.size() == 0);
        fifo_dout  = (q.size() > 0) ? q[0] : 8'h00;
    endtask

    task automatic model_reset();
        m_in   = 1'b0;
        m_t    = 0;
        m_len  = 1;
        m_bits = '1;
        e_tx   = 1'b1;
        e_busy = 1'b0;
        e_rd   = 1'b0;
    endtask

    // Predict the outputs for the cycle after the next rising edge, using
    // the inputs as they stand now.
    task automatic model_advance();
        logic [7:0] d;
        bit started;
        started = 1'b0;
        if (m_in) begin
            if (m_t == NB * m_len - 1) m_in = 1'b0;
            else m_t++;
        end
        if (!m_in && tx_en && q.size() > 0) begin
            d      = q[0];
            m_in   = 1'b1;
            m_t    = 0;
            m_len  = int'(baud_div) + 1;
            m_bits = '1;
            m_bits[0] = 1'b0;
            for (int i = 0; i < 8; i++) m_bits[1 + i] = d[i];
            if (PAR) m_bits[9] = (^d) ^ parity_odd;
            started = 1'b1;
        end
        e_rd   = started;
        e_busy = m_in;
        e_tx   = m_in ? m_bits[m_t / m_len] : 1'b1;
    endtask

    task automatic reset_stats();
        n_busy = 0;
        n_rd   = 0;
        n_rise = 0;
        prev_busy = busy;
        obs.delete();
    endtask

    task automatic cycle();
        model_advance();
        @(negedge clk);
        check("tx", {31'd0, tx}, {31'd0, e_tx});
        check("busy", {31'd0, busy}, {31'd0, e_busy});
        check("fifo_rd_en", {31'd0, fifo_rd_en}, {31'd0, e_rd});
        if (busy) begin
            n_busy++;
            obs.push_back(tx);
        end
        if (fifo_rd_en) n_rd++;
        if (busy && !prev_busy) n_rise++;
        prev_busy = busy;
        if (fifo_rd_en) begin
            if (q.size() > 0) void'(q.pop_front());
            fifo_sync();
        end
    endtask

    task automatic run_single(input logic p);
        logic exp_seq [11];
        exp_seq = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        if (PAR) exp_seq[9] = p;
        tx_en = 1'b0;
        parity_odd = p;
        baud_div = 16'd3;
        reset_stats();
        q.push_back(8'hA5);
        fifo_sync();
        tx_en = 1'b1;
        repeat (NB * 4 + 6) cycle();
        check("single_rd_count", n_rd, 1);
        check("single_busy_cycles", n_busy, NB * 4);
        check("single_busy_rises", n_rise, 1);
        check("single_obs_len", obs.size(), NB * 4);
        if (obs.size() == NB * 4) begin
            for (int i = 0; i < NB; i++)
                check($sformatf("single_bit%0d", i), {31'd0, obs[4 * i + 2]}, {31'd0, exp_seq[i]});
        end
    endtask

    initial begin
        fifo_sync();
        model_reset();
        repeat (2) @(negedge clk);
        check("reset_tx", {31'd0, tx}, 1);
        check("reset_busy", {31'd0, busy}, 0);
        check("reset_rd_en", {31'd0, fifo_rd_en}, 0);
        rst_n = 1'b1;
        repeat (3) cycle();

        // Single byte, both parity senses.
        run_single(1'b0);
        run_single(1'b1);

        // Back-to-back frames at one cycle per bit.
        tx_en = 1'b0;
        baud_div = 16'd0;
        reset_stats();
        q.push_back(8'h00);
        q.push_back(8'hFF);
        fifo_sync();
        tx_en = 1'b1;
        repeat (2 * NB + 5) cycle();
        check("b2b_rd_count", n_rd, 2);
        check("b2b_busy_cycles", n_busy, 2 * NB);
        check("b2b_busy_rises", n_rise, 1);
        check("b2b_fifo_left", q.size(), 0);

        // Divisor change mid-frame only affects the following frame.
        tx_en = 1'b0;
        baud_div = 16'd3;
        reset_stats();
        q.push_back(8'h3C);
        q.push_back(8'hA5);
        fifo_sync();
        tx_en = 1'b1;
        repeat (10) cycle();
        baud_div = 16'd7;
        repeat (NB * 12 + 10) cycle();
        check("div_busy_cycles", n_busy, NB * 12);
        check("div_rd_count", n_rd, 2);
        if (obs.size() == NB * 12) begin
            check("div_f1_stop", {31'd0, obs[NB * 4 - 1]}, 1);
            check("div_f2_start_end", {31'd0, obs[NB * 4 + 7]}, 0);
            check("div_f2_bit0", {31'd0, obs[NB * 4 + 8]}, 1);
        end else begin
            check("div_obs_len", obs.size(), NB * 12);
        end

        // tx_en dropped mid-frame: the frame finishes, nothing else pops.
        baud_div = 16'd1;
        reset_stats();
        q.push_back(8'h11);
        q.push_back(8'h22);
        q.push_back(8'h33);
        fifo_sync();
        repeat (6) cycle();
        tx_en = 1'b0;
        repeat (NB * 2 + 10) cycle();
        check("gate_rd_count", n_rd, 1);
        check("gate_fifo_left", q.size(), 2);
        check("gate_busy_cycles", n_busy, NB * 2);
        tx_en = 1'b1;
        repeat (4) cycle();
        check("gate_resume_rd", n_rd, 2);
        tx_en = 1'b0;
        repeat (NB * 2 + 4) cycle();

        // Asynchronous reset in the middle of the data bits.
        baud_div = 16'd3;
        tx_en = 1'b1;
        repeat (15) cycle();
        check("pre_reset_busy", {31'd0, busy}, 1);
        rst_n = 1'b0;
        #1;
        check("midreset_tx", {31'd0, tx}, 1);
        check("midreset_busy", {31'd0, busy}, 0);
        check("midreset_rd_en", {31'd0, fifo_rd_en}, 0);
        tx_en = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        reset_stats();
        repeat (6) cycle();
        check("post_reset_idle", n_busy, 0);

        // Randomised traffic, divisors and enables.
        for (int it = 0; it < 60; it++) begin
            int np;
            np = $urandom_range(0, 2);
            for (int k = 0; k < np; k++) begin
                if (q.size() < 4) q.push_back(8'($urandom));
            end
            fifo_sync();
            tx_en = ($urandom_range(0, 3) != 0);
            baud_div = 16'($urandom_range(0, 3));
            parity_odd = 1'($urandom);
            repeat ($urandom_range(5, 40)) cycle();
        end
        tx_en = 1'b1;
        repeat (300) cycle();
        check("drain_fifo_left", q.size(), 0);
        check("drain_busy", {31'd0, busy}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
